// File: rtl/key_scheduler.sv
// ---------------------------------------------------------------------------
// key_scheduler
//   Builds the RC4 working state in a shared 256x8 scratch RAM: first writes
//   the identity permutation, then runs the 256-iteration key-scheduling swap
//   loop. Owns the scratch port until `finish`, after which the top level
//   hands the port to the decrypter.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   key     in   secret key, byte 0 in the most significant byte
//   start   in   level request, sampled in IDLE
//   finish  out  high while in DONE
//   s_addr  out  scratch address
//   s_data  out  scratch write data
//   s_wren  out  scratch write enable
//   s_q     in   scratch read data (one-cycle synchronous read)
// ---------------------------------------------------------------------------
module key_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int KEY_LEN    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*KEY_LEN-1:0]    key,
  input  logic                    start,
  output logic                    finish,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_wren,
  input  logic [DATA_WIDTH-1:0]   s_q
);

  // Width of the key-byte index counter (i mod KEY_LEN).
  localparam int KCW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [KCW-1:0] KC_LAST = KCW'(KEY_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_RD_I,
    S_WAIT_I,
    S_CALC_J,
    S_RD_J,
    S_WR_I,
    S_WR_J,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic [ADDR_WIDTH-1:0]    r_i;
  logic [ADDR_WIDTH-1:0]    r_j;
  logic [DATA_WIDTH-1:0]    r_si;
  logic [8*KEY_LEN-1:0]     r_key;
  logic [KCW-1:0]           r_kidx;

  logic [7:0]               w_key_byte;
  logic [ADDR_WIDTH-1:0]    w_j_next;
  logic                     w_i_last;

  assign w_i_last = (r_i == '1);

  // Key byte selected by the i mod KEY_LEN counter; byte 0 is the MSB.
  always_comb begin
    w_key_byte = '0;
    for (int unsigned b = 0; b < KEY_LEN; b++) begin
      if (r_kidx == KCW'(b)) begin
        w_key_byte = r_key[8*(KEY_LEN-1-b) +: 8];
      end
    end
  end

  assign w_j_next = r_j + ADDR_WIDTH'(r_si) + ADDR_WIDTH'(w_key_byte);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i    <= '0;
      r_j    <= '0;
      r_si   <= '0;
      r_key  <= '0;
      r_kidx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key  <= key;
            r_i    <= '0;
            r_j    <= '0;
            r_kidx <= '0;
          end
        end
        S_INIT: begin
          r_i <= r_i + ADDR_WIDTH'(1);
          if (w_i_last) begin
            r_j    <= '0;
            r_kidx <= '0;
          end
        end
        S_WAIT_I: begin
          r_si <= s_q;
        end
        S_CALC_J: begin
          r_j <= w_j_next;
        end
        S_WR_J: begin
          r_i    <= r_i + ADDR_WIDTH'(1);
          r_kidx <= (r_kidx == KC_LAST) ? '0 : r_kidx + KCW'(1);
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and Moore outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    finish       = 1'b0;
    s_addr       = '0;
    s_data       = '0;
    s_wren       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_INIT;
      end
      S_INIT: begin
        s_wren = 1'b1;
        s_addr = r_i;
        s_data = DATA_WIDTH'(r_i);
        if (w_i_last) w_state_next = S_RD_I;
      end
      S_RD_I: begin
        s_addr       = r_i;
        w_state_next = S_WAIT_I;
      end
      S_WAIT_I: begin
        s_addr       = r_i;
        w_state_next = S_CALC_J;
      end
      S_CALC_J: begin
        w_state_next = S_RD_J;
      end
      S_RD_J: begin
        s_addr       = r_j;
        w_state_next = S_WR_I;
      end
      S_WR_I: begin
        // s[j] arrives this cycle from the RD_J read and is written
        // straight back to s[i]; no holding register is needed.
        s_wren       = 1'b1;
        s_addr       = r_i;
        s_data       = s_q;
        w_state_next = S_WR_J;
      end
      S_WR_J: begin
        s_wren       = 1'b1;
        s_addr       = r_j;
        s_data       = r_si;
        w_state_next = w_i_last ? S_DONE : S_RD_I;
      end
      S_DONE: begin
        finish = 1'b1;
        if (!start) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_key_scheduler.sv
module tb_key_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] key;
  logic        finish;
  logic [7:0]  s_addr;
  logic [7:0]  s_data;
  logic        s_wren;
  logic [7:0]  s_q;

  int tests  = 0;
  int fails  = 0;
  int cyc    = 0;
  int wr_cnt = 0;

  logic [7:0] mem  [256];
  logic [7:0] gold [256];

  always #5 clk = ~clk;

  key_scheduler #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .KEY_LEN    (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .start  (start),
    .finish (finish),
    .s_addr (s_addr),
    .s_data (s_data),
    .s_wren (s_wren),
    .s_q    (s_q)
  );

  // Scratch RAM: synchronous read returning the pre-write contents.
  always @(posedge clk) begin
    s_q <= mem[s_addr];
    if (s_wren === 1'b1) mem[s_addr] <= s_data;
  end

  always @(posedge clk) begin
    if (s_wren === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  typedef struct {
    logic [23:0] key;
    int          cyc;
    logic        wren;
    logic        chk_addr;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        fin;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [23:0] k, input int c, input logic w,
                     input logic ca, input logic [7:0] a, input logic [7:0] d,
                     input logic f);
    vec_t v;
    v.key = k; v.cyc = c; v.wren = w; v.chk_addr = ca;
    v.addr = a; v.data = d; v.fin = f;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Leaves the bench in cycle 0: IDLE with start=1 about to be sampled.
  task automatic start_run(input logic [23:0] k);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    cyc   = 0;
  endtask

  task automatic compute_gold(input logic [23:0] k);
    logic [7:0] kb [3];
    logic [7:0] t;
    int j;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int i = 0; i < 256; i++) gold[i] = 8'(i);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(gold[i]) + int'(kb[i % 3])) % 256;
      t = gold[i];
      gold[i] = gold[j];
      gold[j] = t;
    end
  endtask

  task automatic check_state(input string tag);
    int bad;
    int missing;
    logic seen [256];
    bad = 0;
    missing = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== gold[i]) bad++;
      if (!$isunknown(mem[i])) seen[mem[i]] = 1'b1;
    end
    for (int i = 0; i < 256; i++) if (!seen[i]) missing++;
    chk({tag, "_state_mismatches"}, bad, 0);
    chk({tag, "_perm_missing"}, missing, 0);
  endtask

  // Full run from start; key switches to alt from cycle 5 on.
  task automatic full_run(input string tag, input logic [23:0] k,
                          input logic [23:0] alt, input bit do_rst);
    int w0;
    int n;
    compute_gold(k);
    if (do_rst) apply_reset();
    start_run(k);
    w0 = wr_cnt;
    n  = 0;
    while (finish !== 1'b1 && n < 2000) begin
      step();
      n++;
      if (cyc >= 5) key = alt;
    end
    chk({tag, "_finish_cycle"}, cyc, 1793);
    chk({tag, "_wren_in_done"}, int'(s_wren), 0);
    chk({tag, "_write_count"}, wr_cnt - w0, 768);
    check_state(tag);
    w0 = wr_cnt;
    repeat (8) step();
    chk({tag, "_finish_held"}, int'(finish), 1);
    chk({tag, "_writes_while_held"}, wr_cnt - w0, 0);
  endtask

  task automatic drop_start(input string tag);
    start = 1'b0;
    step();
    chk({tag, "_finish_after_drop"}, int'(finish), 0);
  endtask

  initial begin
    logic [23:0] cur_key;
    bit          running;
    int          w0;

    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hA5;
    repeat (3) @(negedge clk);
    chk("reset_wren",   int'(s_wren), 0);
    chk("reset_addr",   int'(s_addr), 0);
    chk("reset_data",   int'(s_data), 0);
    chk("reset_finish", int'(finish), 0);
    rst = 1'b0;

    // key, cycle, wren, check addr, addr, data, finish
    add(24'h030000,   0, 0, 0, 8'h00, 8'h00, 0);
    add(24'h030000,   1, 1, 1, 8'h00, 8'h00, 0);
    add(24'h030000,   2, 1, 1, 8'h01, 8'h01, 0);
    add(24'h030000, 100, 1, 1, 8'h63, 8'h63, 0);
    add(24'h030000, 256, 1, 1, 8'hFF, 8'hFF, 0);
    add(24'h030000, 257, 0, 1, 8'h00, 8'h00, 0);
    add(24'h030000, 260, 0, 1, 8'h03, 8'h00, 0);
    add(24'h030000, 261, 1, 1, 8'h00, 8'h03, 0);
    add(24'h030000, 262, 1, 1, 8'h03, 8'h00, 0);
    add(24'h030000, 263, 0, 1, 8'h01, 8'h00, 0);
    add(24'h030000, 267, 1, 1, 8'h01, 8'h04, 0);
    add(24'h030000, 268, 1, 1, 8'h04, 8'h01, 0);
    add(24'h030000, 273, 1, 1, 8'h02, 8'h06, 0);
    add(24'h030000, 274, 1, 1, 8'h06, 8'h02, 0);
    add(24'h000000, 261, 1, 1, 8'h00, 8'h00, 0);
    add(24'h000000, 262, 1, 1, 8'h00, 8'h00, 0);

    running = 1'b0;
    cur_key = '0;
    foreach (vecs[v]) begin
      if (!running || vecs[v].key != cur_key || vecs[v].cyc < cyc) begin
        apply_reset();
        start_run(vecs[v].key);
        cur_key = vecs[v].key;
        running = 1'b1;
      end
      while (cyc < vecs[v].cyc) step();
      chk($sformatf("k%h_c%0d_wren", cur_key, cyc), int'(s_wren), int'(vecs[v].wren));
      chk($sformatf("k%h_c%0d_finish", cur_key, cyc), int'(finish), int'(vecs[v].fin));
      if (vecs[v].chk_addr)
        chk($sformatf("k%h_c%0d_addr", cur_key, cyc), int'(s_addr), int'(vecs[v].addr));
      if (vecs[v].wren)
        chk($sformatf("k%h_c%0d_data", cur_key, cyc), int'(s_data), int'(vecs[v].data));
    end
    // Run remains in progress from the table: s[0] must end as 0 after i==j swap.
    while (cyc < 263) step();
    chk("ieqj_s0_after_swap", int'(mem[0]), 0);

    full_run("k000000", 24'h000000, 24'h000000, 1'b1);
    drop_start("k000000");
    full_run("kFFFFFF", 24'hFFFFFF, 24'hFFFFFF, 1'b1);
    drop_start("kFFFFFF");
    full_run("k1A2B3C", 24'h1A2B3C, 24'h1A2B3C, 1'b0);
    drop_start("k1A2B3C");

    // Reset in the middle of the swap loop.
    start_run(24'h1A2B3C);
    while (cyc < 900) step();
    rst   = 1'b1;
    start = 1'b0;
    #1;
    chk("midrst_wren",   int'(s_wren), 0);
    chk("midrst_addr",   int'(s_addr), 0);
    chk("midrst_data",   int'(s_data), 0);
    chk("midrst_finish", int'(finish), 0);
    w0 = wr_cnt;
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("midrst_no_writes", wr_cnt - w0, 0);
    full_run("midrst_rerun", 24'h1A2B3C, 24'h1A2B3C, 1'b0);
    drop_start("midrst_rerun");

    // Key changes after cycle 0 must not affect the result.
    full_run("keychg", 24'h5AC311, 24'hF00F77, 1'b1);
    drop_start("keychg");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
